sfm_streamer_sched: RTL and testbench



---
 rtl/sfm_pkg.sv | 45 ++++
 rtl/sfm_sched_ctrl_gen.sv | 37 +++
 rtl/sfm_streamer_sched.sv | 182 ++++++++++++++++++
 tb/tb_sfm_streamer_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfm_pkg.sv
// Shared types for the softmax streamer sequencer: streamer control/flag
// payloads, the scheduler FSM states and the latched job configuration.
package sfm_pkg;

  localparam int unsigned SFM_DATA_W        = 288;
  localparam int unsigned SFM_PAYLOAD_BYTES = (SFM_DATA_W - 32) / 8;
  localparam int unsigned SFM_LEN_W         = 20;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_len;
    logic [31:0] d1_stride;
    logic [31:0] d2_stride;
  } hci_streamer_addr_t;

  typedef struct packed {
    logic               req_start;
    hci_streamer_addr_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } hci_streamer_flags_t;

`ifdef SFM_SCHED_WATCHDOG_EN
  typedef enum logic [2:0] {
    SFM_IDLE, SFM_LOAD1, SFM_WAIT1, SFM_ACC, SFM_NORM, SFM_WAIT2, SFM_DONE, SFM_ERR
  } sfm_sched_state_e;
`else
  typedef enum logic [2:0] {
    SFM_IDLE, SFM_LOAD1, SFM_WAIT1, SFM_ACC, SFM_NORM, SFM_WAIT2, SFM_DONE
  } sfm_sched_state_e;
`endif

  typedef struct packed {
    logic [31:0]          in_addr;
    logic [31:0]          out_addr;
    logic [SFM_LEN_W-1:0] len;
  } sfm_sched_cfg_t;

endpackage

// File: rtl/sfm_sched_ctrl_gen.sv
// Builds a registered 1-D streamer control word from base address, beat count
// and a single-cycle request.
module sfm_sched_ctrl_gen
  import sfm_pkg::*;
#(
  parameter int unsigned LEN_W    = 20,
  parameter int unsigned STRIDE_B = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        i_base_addr,
  input  logic [LEN_W:0]     i_beats,
  input  logic               i_req,
  output hci_streamer_ctrl_t o_ctrl
);

  hci_streamer_ctrl_t w_ctrl;

  // Contiguous single-dimension walk; higher dimensions unused.
  always_comb begin
    w_ctrl                           = '0;
    w_ctrl.req_start                 = i_req;
    w_ctrl.addressgen_ctrl.base_addr = i_base_addr;
    w_ctrl.addressgen_ctrl.tot_len   = 32'(i_beats);
    w_ctrl.addressgen_ctrl.d0_len    = 32'(i_beats);
    w_ctrl.addressgen_ctrl.d0_stride = 32'(STRIDE_B);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_ctrl <= '0;
    end else begin
      o_ctrl <= w_ctrl;
    end
  end

endmodule

// File: rtl/sfm_streamer_sched.sv
// Two-pass TCDM streamer sequencer for the softmax engine (load pass, then
// concurrent load/store pass). Optional watchdog: SFM_SCHED_WATCHDOG_EN.
module sfm_streamer_sched
  import sfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 288,
  parameter int unsigned ELEM_W     = 16,
  parameter int unsigned LEN_W      = 20,
  parameter int unsigned WDT_CYCLES = 65535
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         in_addr_i,
  input  logic [31:0]         out_addr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                acc_done_i,
  output hci_streamer_ctrl_t  in_stream_ctrl_o,
  output hci_streamer_ctrl_t  out_stream_ctrl_o,
  input  hci_streamer_flags_t in_stream_flags_i,
  input  hci_streamer_flags_t out_stream_flags_i,
  output logic                pass_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned PAY_W   = DATA_WIDTH - 32;
  localparam int unsigned PAY_B   = PAY_W / 8;
  localparam int unsigned PROD_W  = LEN_W + 32;

  sfm_sched_state_e r_state, w_state_nxt;
  sfm_sched_cfg_t   r_cfg;
  logic             r_in_seen, r_out_seen;
  logic             w_in_req_c, w_out_req_c;
  logic [PROD_W-1:0] w_bits;
  logic [LEN_W:0]    w_beats;

`ifdef SFM_SCHED_WATCHDOG_EN
  logic [31:0] r_wdt_cnt;
  logic        w_wdt_act, w_wdt_trip;

  assign w_wdt_act  = (r_state == SFM_WAIT1) || (r_state == SFM_ACC) || (r_state == SFM_WAIT2);
  assign w_wdt_trip = w_wdt_act && (r_wdt_cnt >= (32'(WDT_CYCLES) - 32'd1));

  // Cycles spent in the current waiting state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdt_cnt <= '0;
    end else if (!w_wdt_act || (w_state_nxt != r_state)) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + 32'd1;
    end
  end
`endif

  // Beats derive from the latched length, so they are frozen for the job.
  assign w_bits  = PROD_W'(r_cfg.len) * PROD_W'(ELEM_W);
  assign w_beats = (LEN_W+1)'((w_bits + PROD_W'(PAY_W - 1)) / PROD_W'(PAY_W));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SFM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_req_c  = 1'b0;
    w_out_req_c = 1'b0;
    if (clear_i) begin
      w_state_nxt = SFM_IDLE;
    end else begin
      unique case (r_state)
        SFM_IDLE: begin
          if (start_i) begin
            w_state_nxt = (len_i != '0) ? SFM_LOAD1 : SFM_DONE;
          end
        end
        SFM_LOAD1: begin
          if (in_stream_flags_i.ready_start) begin
            w_in_req_c  = 1'b1;
            w_state_nxt = SFM_WAIT1;
          end
        end
        SFM_WAIT1: begin
          if (in_stream_flags_i.done) w_state_nxt = SFM_ACC;
        end
        SFM_ACC: begin
          if (acc_done_i) w_state_nxt = SFM_NORM;
        end
        SFM_NORM: begin
          // Both streamers must launch together so load and store stay aligned.
          if (in_stream_flags_i.ready_start && out_stream_flags_i.ready_start) begin
            w_in_req_c  = 1'b1;
            w_out_req_c = 1'b1;
            w_state_nxt = SFM_WAIT2;
          end
        end
        SFM_WAIT2: begin
          if ((r_in_seen || in_stream_flags_i.done) && (r_out_seen || out_stream_flags_i.done)) begin
            w_state_nxt = SFM_DONE;
          end
        end
        SFM_DONE: w_state_nxt = SFM_IDLE;
`ifdef SFM_SCHED_WATCHDOG_EN
        SFM_ERR:  w_state_nxt = SFM_ERR;
`endif
        default:  w_state_nxt = SFM_IDLE;
      endcase
`ifdef SFM_SCHED_WATCHDOG_EN
      if (w_wdt_trip && (w_state_nxt == r_state)) begin
        w_state_nxt = SFM_ERR;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg <= '0;
    end else if ((r_state == SFM_IDLE) && start_i && !clear_i) begin
      r_cfg.in_addr  <= in_addr_i;
      r_cfg.out_addr <= out_addr_i;
      r_cfg.len      <= SFM_LEN_W'(len_i);
    end
  end

  // Streamer completions may arrive in either order during pass 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_seen  <= 1'b0;
      r_out_seen <= 1'b0;
    end else if (clear_i || (r_state != SFM_WAIT2)) begin
      r_in_seen  <= 1'b0;
      r_out_seen <= 1'b0;
    end else begin
      r_in_seen  <= r_in_seen  | in_stream_flags_i.done;
      r_out_seen <= r_out_seen | out_stream_flags_i.done;
    end
  end

  sfm_sched_ctrl_gen #(
    .LEN_W    (LEN_W),
    .STRIDE_B (PAY_B)
  ) u_in_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_base_addr (r_cfg.in_addr),
    .i_beats     (w_beats),
    .i_req       (w_in_req_c),
    .o_ctrl      (in_stream_ctrl_o)
  );

  sfm_sched_ctrl_gen #(
    .LEN_W    (LEN_W),
    .STRIDE_B (PAY_B)
  ) u_out_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_base_addr (r_cfg.out_addr),
    .i_beats     (w_beats),
    .i_req       (w_out_req_c),
    .o_ctrl      (out_stream_ctrl_o)
  );

  assign pass_o = (r_state == SFM_NORM) || (r_state == SFM_WAIT2);
  assign done_o = (r_state == SFM_DONE);

`ifdef SFM_SCHED_WATCHDOG_EN
  assign busy_o = !((r_state == SFM_IDLE) || (r_state == SFM_ERR));
  assign err_o  = (r_state == SFM_ERR);
`else
  assign busy_o = (r_state != SFM_IDLE);
  assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sfm_streamer_sched.sv
// Randomized job-level bench for sfm_streamer_sched against a timing/beat model.
module tb_sfm_streamer_sched;
  import sfm_pkg::*;

  localparam int unsigned DW  = 288;
  localparam int unsigned EW  = 16;
  localparam int unsigned LW  = 20;
  localparam int unsigned WDT = 50;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic                start = 1'b0;
  logic                acc_done = 1'b0;
  logic [31:0]         in_addr = '0;
  logic [31:0]         out_addr = '0;
  logic [LW-1:0]       len = '0;
  hci_streamer_flags_t in_flags = '0;
  hci_streamer_flags_t out_flags = '0;
  hci_streamer_ctrl_t  in_ctrl, out_ctrl;
  logic                pass, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sfm_streamer_sched #(
    .DATA_WIDTH (DW),
    .ELEM_W     (EW),
    .LEN_W      (LW),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .clear_i            (clear),
    .start_i            (start),
    .in_addr_i          (in_addr),
    .out_addr_i         (out_addr),
    .len_i              (len),
    .acc_done_i         (acc_done),
    .in_stream_ctrl_o   (in_ctrl),
    .out_stream_ctrl_o  (out_ctrl),
    .in_stream_flags_i  (in_flags),
    .out_stream_flags_i (out_flags),
    .pass_o             (pass),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic longint exp_beats(input longint l);
    return (l * EW + (DW - 32) - 1) / (DW - 32);
  endfunction

  // mode 0: full job, 1: clear (with start) while pass 1 runs, 2: watchdog in ACC
  task automatic run_job(input logic [LW-1:0] l, input int d_rdy, input int d_in_done,
                         input int d_acc, input int d_out_lag, input int a_out, input int b_in,
                         input int mode);
    logic [31:0] ia, oa;
    longint      bt;
    int          m;
    ia = $urandom;
    oa = $urandom;
    bt = exp_beats(longint'(l));
    start = 1'b1; in_addr = ia; out_addr = oa; len = l;
    in_flags = '0; out_flags = '0;
    tick();
    start = 1'b0; in_addr = $urandom; out_addr = $urandom; len = LW'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
    if (l == '0) begin
      chk("len0_done", 64'(done), 64'(1));
      chk("len0_in_req", 64'(in_ctrl.req_start), 64'(0));
      chk("len0_out_req", 64'(out_ctrl.req_start), 64'(0));
      tick();
      chk("len0_done_fall", 64'(done), 64'(0));
      chk("len0_busy_fall", 64'(busy), 64'(0));
      chk("len0_no_req", 64'(in_ctrl.req_start | out_ctrl.req_start), 64'(0));
      return;
    end
    chk("p1_done_low", 64'(done), 64'(0));
    chk("p1_pass", 64'(pass), 64'(0));
    chk("p1_req_early", 64'(in_ctrl.req_start), 64'(0));
    for (int i = 0; i <= d_rdy; i++) begin
      in_flags.ready_start = (i == d_rdy);
      tick();
      chk("p1_in_req", 64'(in_ctrl.req_start), 64'(i == d_rdy));
      chk("p1_out_req", 64'(out_ctrl.req_start), 64'(0));
    end
    chk("p1_base", 64'(in_ctrl.addressgen_ctrl.base_addr), 64'(ia));
    chk("p1_tot_len", 64'(in_ctrl.addressgen_ctrl.tot_len), 64'(bt));
    chk("p1_d0_len", 64'(in_ctrl.addressgen_ctrl.d0_len), 64'(bt));
    chk("p1_d0_stride", 64'(in_ctrl.addressgen_ctrl.d0_stride), 64'((DW - 32) / 8));
    chk("p1_hi_dims", 64'(in_ctrl.addressgen_ctrl.d1_len | in_ctrl.addressgen_ctrl.d1_stride
                          | in_ctrl.addressgen_ctrl.d2_stride), 64'(0));
    in_flags.ready_start = 1'($urandom);
    tick();
    chk("p1_req_pulse", 64'(in_ctrl.req_start), 64'(0));
    for (int i = 0; i < d_in_done; i++) begin
      tick();
      chk("wait1_busy", 64'(busy), 64'(1));
    end
    if (mode == 1) begin
      clear = 1'b1; start = 1'b1; len = LW'(5);
      tick();
      clear = 1'b0; start = 1'b0;
      chk("clr_busy", 64'(busy), 64'(0));
      chk("clr_done", 64'(done), 64'(0));
      chk("clr_req", 64'(in_ctrl.req_start | out_ctrl.req_start), 64'(0));
      in_flags.done = 1'b1;
      tick();
      in_flags.done = 1'b0;
      chk("clr_idle_busy", 64'(busy), 64'(0));
      tick();
      chk("clr_idle_done", 64'(done), 64'(0));
      chk("clr_idle_req", 64'(in_ctrl.req_start), 64'(0));
      return;
    end
    in_flags.done = 1'b1;
    tick();
    in_flags.done = 1'b0;
    chk("acc_pass", 64'(pass), 64'(0));
`ifdef SFM_SCHED_WATCHDOG_EN
    if (mode == 2) begin
      for (int k = 1; k <= int'(WDT) + 5; k++) begin
        tick();
        chk("wdt_err", 64'(err), 64'(k >= int'(WDT)));
        chk("wdt_busy", 64'(busy), 64'(k < int'(WDT)));
        chk("wdt_done", 64'(done), 64'(0));
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("wdt_clr_err", 64'(err), 64'(0));
      chk("wdt_clr_busy", 64'(busy), 64'(0));
      return;
    end
`endif
    // Stray start and stray done while accumulating must both be ignored.
    start = 1'b1; in_addr = $urandom; out_addr = $urandom; len = LW'(1); in_flags.done = 1'b1;
    tick();
    start = 1'b0; in_flags.done = 1'b0;
    chk("acc_stray_pass", 64'(pass), 64'(0));
    for (int i = 0; i < d_acc; i++) begin
      tick();
      chk("acc_hold_pass", 64'(pass), 64'(0));
    end
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("norm_pass", 64'(pass), 64'(1));
    chk("norm_no_req", 64'(in_ctrl.req_start | out_ctrl.req_start), 64'(0));
    for (int i = 0; i <= d_out_lag; i++) begin
      in_flags.ready_start  = 1'b1;
      out_flags.ready_start = (i == d_out_lag);
      in_flags.done = (i == 0);
      tick();
      in_flags.done = 1'b0;
      chk("p2_in_req", 64'(in_ctrl.req_start), 64'(i == d_out_lag));
      chk("p2_out_req", 64'(out_ctrl.req_start), 64'(i == d_out_lag));
    end
    chk("p2_out_base", 64'(out_ctrl.addressgen_ctrl.base_addr), 64'(oa));
    chk("p2_in_base", 64'(in_ctrl.addressgen_ctrl.base_addr), 64'(ia));
    chk("p2_out_tot", 64'(out_ctrl.addressgen_ctrl.tot_len), 64'(bt));
    chk("p2_out_stride", 64'(out_ctrl.addressgen_ctrl.d0_stride), 64'((DW - 32) / 8));
    in_flags.ready_start = 1'b0; out_flags.ready_start = 1'b0;
    m = (a_out > b_in) ? a_out : b_in;
    for (int c = 0; c <= m; c++) begin
      in_flags.done  = (c == b_in);
      out_flags.done = (c == a_out);
      tick();
      chk("w2_req", 64'(in_ctrl.req_start | out_ctrl.req_start), 64'(0));
      chk("w2_done", 64'(done), 64'(c == m));
      chk("w2_busy", 64'(busy), 64'(1));
      if (c < m) chk("w2_pass", 64'(pass), 64'(1));
    end
    in_flags.done = 1'b0; out_flags.done = 1'b0;
    tick();
    chk("end_done", 64'(done), 64'(0));
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_pass", 64'(pass), 64'(0));
    chk("end_err", 64'(err), 64'(0));
  endtask

  initial begin
    logic [LW-1:0] rl;
    int            sel;
    tick();
    tick();
    chk("rst_in_ctrl", 64'(in_ctrl == '0), 64'(1));
    chk("rst_out_ctrl", 64'(out_ctrl == '0), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    rst_n = 1'b1;
    tick();

    run_job(LW'(100), 0, 2, 2, 5, 0, 3, 0);
    run_job(LW'(100), 0, 1, 1, 0, 2, 2, 0);
    run_job(LW'(100), 3, 0, 0, 0, 3, 0, 0);
    run_job(LW'(0), 0, 0, 0, 0, 0, 0, 0);
    run_job(LW'(37), 1, 2, 0, 0, 0, 0, 1);
    run_job(LW'(37), 0, 0, 0, 1, 1, 0, 0);
`ifdef SFM_SCHED_WATCHDOG_EN
    run_job(LW'(20), 0, 1, 0, 0, 0, 0, 2);
    run_job(LW'(20), 0, 1, 1, 1, 1, 1, 0);
`endif

    for (int j = 0; j < 30; j++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       rl = '0;
        1:       rl = LW'(1);
        2:       rl = '1;
        default: rl = LW'($urandom_range(1, 4000));
      endcase
      run_job(rl, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              (($urandom_range(0, 5) == 0) ? 1 : 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
